bias_sweep_ctrl: RTL and testbench

Parametrised successor of the diode bias ramp controller. It steps a DAC code upward, writes each code through the SPI DAC writer with a start/done handshake, and listens for avalanche noise in a timed window after each step. Once a configurable number of consecutive windows are noisy, it backs off by a fixed number of codes, writes the final code and asserts `varu`. It sits between the noise comparator/synchroniser and the SPI DAC writer.

---
 rtl/bias_sweep_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bias_sweep_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_sweep_ctrl.sv
// Diode bias sweep controller: ramps a DAC code, listens for avalanche noise after each
// write, and backs off a fixed number of codes once noise has been confirmed.
module bias_sweep_ctrl #(
    parameter int DAC_W        = 8,
    parameter int STEP         = 1,
    parameter int DWELL_TICKS  = 19000,
    parameter int SETTLE_TICKS = 250,
    parameter int WINDOW_TICKS = 5750,
    parameter int CONFIRM_WIN  = 3,
    parameter int BACKOFF      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             noise_valid,
    input  logic             spi_done,
    output logic [DAC_W-1:0] voltage,
    output logic             spi_start,
    output logic             varu,
    output logic             fail,
    output logic             busy,
    output logic [2:0]       debug_state,
    output logic [3:0]       debug_window_count
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE_WAIT = 3'd1,
        SETTLE     = 3'd2,
        WINDOW     = 3'd3,
        DWELL      = 3'd4,
        FINAL_WAIT = 3'd5,
        DONE       = 3'd6,
        FAIL       = 3'd7
    } state_t;

    localparam int T_MAX_A = (DWELL_TICKS > SETTLE_TICKS) ? DWELL_TICKS : SETTLE_TICKS;
    localparam int T_MAX   = (T_MAX_A > WINDOW_TICKS) ? T_MAX_A : WINDOW_TICKS;
    localparam int TIMER_W = $clog2(T_MAX + 1);

    localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_TICKS - 1);
    localparam logic [TIMER_W-1:0] WINDOW_LAST  = TIMER_W'(WINDOW_TICKS - 1);
    localparam logic [TIMER_W-1:0] DWELL_LAST   = TIMER_W'(DWELL_TICKS - 1);
    localparam logic [3:0]         CONFIRM_LAST = 4'(CONFIRM_WIN - 1);
    localparam int                 TOP_LIMIT    = (1 << DAC_W) - 1 - STEP;
    localparam logic [DAC_W-1:0]   STEP_V       = DAC_W'(STEP);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         window_count;
    logic               noise_flag;
    logic               noisy;
    logic [DAC_W-1:0]   backoff_code;

    assign noisy = noise_flag | noise_valid;

    // Saturate at zero rather than wrapping when BACKOFF exceeds the current code.
    assign backoff_code = (int'(voltage) <= BACKOFF) ? '0 : DAC_W'(int'(voltage) - BACKOFF);

    assign debug_state        = state;
    assign debug_window_count = window_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            window_count <= '0;
            noise_flag   <= 1'b0;
            voltage      <= '0;
            spi_start    <= 1'b0;
            varu         <= 1'b0;
            fail         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // NOTE: this default is overridden later in the same block; with non-blocking
            // assignments the last write wins, so spi_start is a single-cycle pulse.
            spi_start <= 1'b0;
            if (abort) begin
                state        <= IDLE;
                timer        <= '0;
                window_count <= '0;
                noise_flag   <= 1'b0;
                varu         <= 1'b0;
                fail         <= 1'b0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE, FAIL: begin
                        if (start) begin
                            voltage      <= '0;
                            window_count <= '0;
                            varu         <= 1'b0;
                            fail         <= 1'b0;
                            spi_start    <= 1'b1;
                            busy         <= 1'b1;
                            state        <= WRITE_WAIT;
                        end
                    end
                    WRITE_WAIT: begin
                        if (spi_done) begin
                            timer <= '0;
                            state <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (timer == SETTLE_LAST) begin
                            timer <= '0;
                            state <= WINDOW;
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end
                    WINDOW: begin
                        if (timer == WINDOW_LAST) begin
                            timer      <= '0;
                            noise_flag <= 1'b0;
                            if (noisy) begin
                                window_count <= window_count + 4'd1;
                                if (window_count == CONFIRM_LAST) begin
                                    voltage   <= backoff_code;
                                    spi_start <= 1'b1;
                                    state     <= FINAL_WAIT;
                                end else begin
                                    state <= DWELL;
                                end
                            end else begin
                                window_count <= '0;
                                if (int'(voltage) > TOP_LIMIT) begin
                                    fail  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= FAIL;
                                end else begin
                                    voltage <= voltage + STEP_V;
                                    state   <= DWELL;
                                end
                            end
                        end else begin
                            timer      <= timer + TIMER_W'(1);
                            noise_flag <= noisy;
                        end
                    end
                    DWELL: begin
                        if (timer == DWELL_LAST) begin
                            timer     <= '0;
                            spi_start <= 1'b1;
                            state     <= WRITE_WAIT;
                        end else begin
                            timer <= timer + TIMER_W'(1);
                        end
                    end
                    FINAL_WAIT: begin
                        if (spi_done) begin
                            varu  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bias_sweep_ctrl.sv
// Scoreboard bench for bias_sweep_ctrl: expected DAC writes are queued by the stimulus
// and popped by a monitor on every spi_start pulse.
module tb_bias_sweep_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start0, abort0, noise0, spi_done0, ack_done0, man_done0, ack_en0;
    logic [W-1:0] voltage0;
    logic         spi_start0, varu0, fail0, busy0;
    logic [2:0]   state0;
    logic [3:0]   count0;

    logic         start1, abort1, noise1, spi_done1;
    logic [W-1:0] voltage1;
    logic         spi_start1, varu1, fail1, busy1;
    logic [2:0]   state1;
    logic [3:0]   count1;

    assign spi_done0 = ack_done0 | man_done0;

    bias_sweep_ctrl #(
        .DAC_W(W), .STEP(1), .DWELL_TICKS(4), .SETTLE_TICKS(2),
        .WINDOW_TICKS(3), .CONFIRM_WIN(3), .BACKOFF(2)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .noise_valid(noise0), .spi_done(spi_done0), .voltage(voltage0),
        .spi_start(spi_start0), .varu(varu0), .fail(fail0), .busy(busy0),
        .debug_state(state0), .debug_window_count(count0)
    );

    bias_sweep_ctrl #(
        .DAC_W(W), .STEP(1), .DWELL_TICKS(4), .SETTLE_TICKS(2),
        .WINDOW_TICKS(3), .CONFIRM_WIN(3), .BACKOFF(8)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .noise_valid(noise1), .spi_done(spi_done1), .voltage(voltage1),
        .spi_start(spi_start1), .varu(varu1), .fail(fail1), .busy(busy1),
        .debug_state(state1), .debug_window_count(count1)
    );

    typedef struct {
        int code;
        int cnt;   // -1: window count not compared
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   mode;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic push0(input int code, input int cnt);
        exp_t e;
        e.code = code;
        e.cnt  = cnt;
        q0.push_back(e);
    endtask

    task automatic push1(input int code, input int cnt);
        exp_t e;
        e.code = code;
        e.cnt  = cnt;
        q1.push_back(e);
    endtask

    task automatic push_range0(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) push0(v, 0);
    endtask

    // Monitors: every write request is matched against the next queued expectation.
    initial begin
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_start0) begin
                check("spi_start_gap0", int'(prev), 0);
                if (q0.size() == 0) begin
                    check("unexpected_write0", int'(voltage0), -1);
                end else begin
                    e = q0.pop_front();
                    check("write_code0", int'(voltage0), e.code);
                    if (e.cnt >= 0) check("write_count0", int'(count0), e.cnt);
                end
            end
            prev = spi_start0;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (spi_start1) begin
                if (q1.size() == 0) begin
                    check("unexpected_write1", int'(voltage1), -1);
                end else begin
                    e = q1.pop_front();
                    check("write_code1", int'(voltage1), e.code);
                    if (e.cnt >= 0) check("write_count1", int'(count1), e.cnt);
                end
            end
        end
    end

    // DAC writer models: acknowledge two cycles after each request.
    initial begin
        ack_done0 = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_start0 && ack_en0) begin
                @(negedge clk);
                @(negedge clk);
                ack_done0 = 1'b1;
                @(negedge clk);
                ack_done0 = 1'b0;
            end
        end
    end

    initial begin
        spi_done1 = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_start1) begin
                @(negedge clk);
                @(negedge clk);
                spi_done1 = 1'b1;
                @(negedge clk);
                spi_done1 = 1'b0;
            end
        end
    end

    // Noise sources: mode 1 noisy from code 6, mode 2 one pulse on the last window
    // cycle at code 5, mode 3 noise only while settling at code 2.
    initial begin
        int  win_cyc;
        int  last_mode;
        bit  pulsed;
        noise0    = 1'b0;
        win_cyc   = 0;
        last_mode = -1;
        pulsed    = 1'b0;
        forever begin
            @(negedge clk);
            if (mode != last_mode) pulsed = 1'b0;
            last_mode = mode;
            win_cyc = (int'(state0) == 3) ? win_cyc + 1 : 0;
            case (mode)
                1: noise0 = (int'(voltage0) >= 6);
                2: begin
                    noise0 = (win_cyc == 3 && int'(voltage0) == 5 && !pulsed);
                    if (noise0) pulsed = 1'b1;
                end
                3: noise0 = (int'(state0) == 2 && int'(voltage0) == 2);
                default: noise0 = 1'b0;
            endcase
        end
    end

    initial begin
        noise1 = 1'b0;
        forever begin
            @(negedge clk);
            noise1 = (int'(voltage1) >= 3);
        end
    end

    task automatic sweep0(input int budget);
        int n;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (busy0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("sweep_timeout0", int'(busy0), 0);
    endtask

    task automatic wait_for0(input int st, input int v, input int budget);
        int n;
        n = 0;
        while (!(int'(state0) == st && int'(voltage0) == v) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_timeout0", (n < budget) ? 0 : 1, 0);
    endtask

    task automatic check_zero0(input string tag);
        check({tag, "_voltage"}, int'(voltage0), 0);
        check({tag, "_spi_start"}, int'(spi_start0), 0);
        check({tag, "_varu"}, int'(varu0), 0);
        check({tag, "_fail"}, int'(fail0), 0);
        check({tag, "_busy"}, int'(busy0), 0);
        check({tag, "_state"}, int'(state0), 0);
        check({tag, "_count"}, int'(count0), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset     = 1'b1;
        start0    = 1'b0;
        abort0    = 1'b0;
        man_done0 = 1'b0;
        ack_en0   = 1'b1;
        start1    = 1'b0;
        abort1    = 1'b0;
        mode      = 0;
        repeat (3) @(negedge clk);
        check_zero0("reset");
        check("reset_voltage1", int'(voltage1), 0);
        check("reset_state1", int'(state1), 0);
        reset = 1'b0;
        @(negedge clk);

        // No noise: every code is written, then the top of range fails.
        mode = 0;
        push_range0(0, 15);
        sweep0(1000);
        check("quiet_fail", int'(fail0), 1);
        check("quiet_varu", int'(varu0), 0);
        check("quiet_voltage", int'(voltage0), 15);
        check("quiet_state", int'(state0), 7);
        check("quiet_sb_empty", q0.size(), 0);

        // Noise held from code 6: three noisy windows at 6, then back off to 4.
        mode = 1;
        push_range0(0, 6);
        push0(6, 1);
        push0(6, 2);
        push0(4, -1);
        sweep0(1000);
        check("noise_varu", int'(varu0), 1);
        check("noise_fail", int'(fail0), 0);
        check("noise_voltage", int'(voltage0), 4);
        check("noise_state", int'(state0), 6);
        check("noise_busy", int'(busy0), 0);
        check("noise_sb_empty", q0.size(), 0);

        // Single pulse on the last window cycle at code 5: count 1, then reset to 0.
        mode = 2;
        push_range0(0, 5);
        push0(5, 1);
        push_range0(6, 15);
        sweep0(1000);
        check("pulse_fail", int'(fail0), 1);
        check("pulse_varu", int'(varu0), 0);
        check("pulse_voltage", int'(voltage0), 15);
        check("pulse_sb_empty", q0.size(), 0);

        // Noise only during SETTLE is ignored.
        mode = 3;
        push_range0(0, 15);
        sweep0(1000);
        check("settle_fail", int'(fail0), 1);
        check("settle_voltage", int'(voltage0), 15);
        check("settle_sb_empty", q0.size(), 0);

        // Abort together with spi_done in WRITE_WAIT at code 3.
        mode = 0;
        push_range0(0, 3);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_for0(4, 3, 500);
        ack_en0 = 1'b0;
        wait_for0(1, 3, 100);
        abort0    = 1'b1;
        man_done0 = 1'b1;
        @(negedge clk);
        abort0    = 1'b0;
        man_done0 = 1'b0;
        check("abort_state", int'(state0), 0);
        check("abort_busy", int'(busy0), 0);
        check("abort_voltage", int'(voltage0), 3);
        check("abort_spi_start", int'(spi_start0), 0);
        check("abort_count", int'(count0), 0);
        repeat (5) @(negedge clk);
        check("abort_stays_idle", int'(state0), 0);
        check("abort_sb_empty", q0.size(), 0);
        ack_en0 = 1'b1;

        // Asynchronous reset in WINDOW; a new start begins again at code 0.
        push_range0(0, 2);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_for0(3, 2, 500);
        #2 reset = 1'b1;
        #1 check_zero0("midreset");
        @(negedge clk);
        reset = 1'b0;
        check("midreset_sb_empty", q0.size(), 0);
        repeat (4) @(negedge clk);
        push0(0, 0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_for0(2, 0, 100);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        check("restart_sb_empty", q0.size(), 0);

        // BACKOFF larger than the confirmed code saturates at 0.
        push1(0, 0);
        push1(1, 0);
        push1(2, 0);
        push1(3, 0);
        push1(3, 1);
        push1(3, 2);
        push1(0, -1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (busy1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("backoff_timeout", int'(busy1), 0);
        check("backoff_varu", int'(varu1), 1);
        check("backoff_fail", int'(fail1), 0);
        check("backoff_voltage", int'(voltage1), 0);
        check("backoff_sb_empty", q1.size(), 0);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
